// File: rtl/reg_interface_burst.sv
// reg_interface_burst: packet controller between the SPI word stream and the register bank / model BRAM.
// Latency: strobes, cfg_done, cfg_error and busy are registered, one cycle after the causing rx_valid.
// Backpressure: none; every rx_valid word is consumed on arrival, truncated frames raise sticky cfg_error.
module reg_interface_burst #(
    parameter int                 DATA_W          = 16,
    parameter int                 ADDR_W          = 8,
    parameter int                 BURST_W         = 7,
    parameter logic [DATA_W-1:0]  START_HEADER    = 16'hA55A,
    parameter logic [ADDR_W-1:0]  MODEL_DATA_ADDR = 8'hFF,
    parameter int                 BRAM_ADDR_W     = 10,
    parameter int                 BRAM_DEPTH      = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   frame_active,
    input  logic                   rx_valid,
    input  logic [DATA_W-1:0]      rx_data,
    output logic                   tx_load,
    output logic [DATA_W-1:0]      tx_data,
    output logic                   reg_wr_en,
    output logic                   reg_rd_en,
    output logic [ADDR_W-1:0]      reg_addr,
    output logic [DATA_W-1:0]      reg_wr_data,
    input  logic [DATA_W-1:0]      reg_rd_data,
    output logic                   bram_wr_en,
    output logic [BRAM_ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0]      bram_wr_data,
    output logic                   cfg_done,
    output logic                   cfg_error,
    output logic                   busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_WRITE, S_READ, S_MODEL, S_DONE, S_ERROR
    } state_t;

    localparam logic [BRAM_ADDR_W-1:0] PTR_LAST = BRAM_ADDR_W'(BRAM_DEPTH - 1);

    state_t                 state, state_nxt;
    logic                   fa_q;
    logic                   fa_fall;
    logic [BURST_W:0]       len_q, len_nxt;
    logic [BURST_W:0]       count_q, count_nxt;
    logic [ADDR_W-1:0]      addr_q, addr_nxt;
    logic [BRAM_ADDR_W-1:0] ptr_q, ptr_nxt;
    logic                   reg_wr_en_nxt, reg_rd_en_nxt, bram_wr_en_nxt, err_nxt;
    logic [ADDR_W-1:0]      reg_addr_nxt;
    logic [DATA_W-1:0]      reg_wr_data_nxt, bram_wr_data_nxt;
    logic [BRAM_ADDR_W-1:0] bram_addr_nxt;
    logic [DATA_W-1:0]      tx_hold;

    assign fa_fall = fa_q & ~frame_active;

    // State register plus the packet bookkeeping registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            fa_q    <= 1'b0;
            len_q   <= '0;
            count_q <= '0;
            addr_q  <= '0;
            ptr_q   <= '0;
        end else begin
            state   <= state_nxt;
            fa_q    <= frame_active;
            len_q   <= len_nxt;
            count_q <= count_nxt;
            addr_q  <= addr_nxt;
            ptr_q   <= ptr_nxt;
        end
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_nxt        = state;
        len_nxt          = len_q;
        count_nxt        = count_q;
        addr_nxt         = addr_q;
        ptr_nxt          = ptr_q;
        reg_wr_en_nxt    = 1'b0;
        reg_rd_en_nxt    = 1'b0;
        bram_wr_en_nxt   = 1'b0;
        reg_addr_nxt     = reg_addr;
        reg_wr_data_nxt  = reg_wr_data;
        bram_addr_nxt    = bram_addr;
        bram_wr_data_nxt = bram_wr_data;
        err_nxt          = cfg_error;

        case (state)
            S_IDLE: begin
                if (rx_valid && rx_data == START_HEADER) begin
                    state_nxt = S_CMD;
                    err_nxt   = 1'b0;
                end
            end
            S_CMD: begin
                if (rx_valid) begin
                    len_nxt   = {1'b0, rx_data[8 +: BURST_W]} + 1'b1;
                    count_nxt = '0;
                    addr_nxt  = rx_data[ADDR_W-1:0];
                    if (rx_data[DATA_W-1]) begin
                        // First read is issued straight away so its data is ready for the next word.
                        state_nxt     = S_READ;
                        reg_rd_en_nxt = 1'b1;
                        reg_addr_nxt  = rx_data[ADDR_W-1:0];
                    end else if (rx_data[ADDR_W-1:0] == MODEL_DATA_ADDR) begin
                        state_nxt = S_MODEL;
                        ptr_nxt   = '0;
                    end else begin
                        state_nxt = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (rx_valid) begin
                    reg_wr_en_nxt   = 1'b1;
                    reg_addr_nxt    = addr_q;
                    reg_wr_data_nxt = rx_data;
                    addr_nxt        = addr_q + 1'b1;
                    count_nxt       = count_q + 1'b1;
                    if (count_nxt == len_q) state_nxt = S_DONE;
                end
            end
            S_READ: begin
                if (rx_valid) begin
                    count_nxt = count_q + 1'b1;
                    if (count_nxt == len_q) begin
                        state_nxt = S_DONE;
                    end else begin
                        addr_nxt      = addr_q + 1'b1;
                        reg_rd_en_nxt = 1'b1;
                        reg_addr_nxt  = addr_q + 1'b1;
                    end
                end
            end
            S_MODEL: begin
                if (rx_valid) begin
                    bram_wr_en_nxt   = 1'b1;
                    bram_addr_nxt    = ptr_q;
                    bram_wr_data_nxt = rx_data;
                    ptr_nxt          = ptr_q + 1'b1;
                    if (ptr_q == PTR_LAST) state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            S_ERROR: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        // A word arriving with the frame fall is processed first; only a completing word escapes the error.
        if (fa_fall && (state == S_CMD || state == S_WRITE || state == S_READ || state == S_MODEL)
            && state_nxt != S_DONE) begin
            state_nxt = S_ERROR;
        end
        if (state_nxt == S_ERROR) err_nxt = 1'b1;
    end

    // Registered strobes and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            reg_wr_en    <= 1'b0;
            reg_rd_en    <= 1'b0;
            tx_load      <= 1'b0;
            reg_addr     <= '0;
            reg_wr_data  <= '0;
            bram_wr_en   <= 1'b0;
            bram_addr    <= '0;
            bram_wr_data <= '0;
            cfg_done     <= 1'b0;
            cfg_error    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            reg_wr_en    <= reg_wr_en_nxt;
            reg_rd_en    <= reg_rd_en_nxt;
            tx_load      <= reg_rd_en_nxt;
            reg_addr     <= reg_addr_nxt;
            reg_wr_data  <= reg_wr_data_nxt;
            bram_wr_en   <= bram_wr_en_nxt;
            bram_addr    <= bram_addr_nxt;
            bram_wr_data <= bram_wr_data_nxt;
            cfg_done     <= (state_nxt == S_DONE);
            cfg_error    <= err_nxt;
            busy         <= (state_nxt != S_IDLE);
        end
    end

    // Read data is only valid while reg_rd_en is high, so it passes through during the
    // load cycle and is held afterwards so tx_data stays stable between reads.
    always_ff @(posedge clk) begin
        if (reset) tx_hold <= '0;
        else if (reg_rd_en) tx_hold <= reg_rd_data;
    end

    assign tx_data = reg_rd_en ? reg_rd_data : tx_hold;

endmodule

// File: tb/tb_reg_interface_burst.sv
module tb_reg_interface_burst;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_active = 1'b0;
    logic        rx_valid = 1'b0;
    logic [15:0] rx_data = '0;
    logic        tx_load, reg_wr_en, reg_rd_en, bram_wr_en, cfg_done, cfg_error, busy;
    logic [15:0] tx_data, reg_wr_data, reg_rd_data, bram_wr_data;
    logic [7:0]  reg_addr;
    logic [9:0]  bram_addr;

    logic [15:0] bank [0:255];
    logic [15:0] body [0:15];
    assign reg_rd_data = bank[reg_addr];

    reg_interface_burst #(
        .DATA_W(16), .ADDR_W(8), .BURST_W(7), .START_HEADER(16'hA55A),
        .MODEL_DATA_ADDR(8'hFF), .BRAM_ADDR_W(10), .BRAM_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .frame_active(frame_active),
        .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_load(tx_load), .tx_data(tx_data),
        .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en), .reg_addr(reg_addr),
        .reg_wr_data(reg_wr_data), .reg_rd_data(reg_rd_data),
        .bram_wr_en(bram_wr_en), .bram_addr(bram_addr), .bram_wr_data(bram_wr_data),
        .cfg_done(cfg_done), .cfg_error(cfg_error), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; int a; logic [15:0] d; } ev_t;
    ev_t wr_q[$], rd_q[$], bm_q[$];
    int  done_q[$], err_q[$];

    int n_cmp = 0, n_bad = 0;
    int n_wr = 0, n_rd = 0, n_bm = 0, n_done = 0;
    int last_wr_addr = 0, last_rd_addr = 0, last_bm_addr = 0;
    logic [15:0] last_wr_data = '0, last_tx = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Per-cycle compare of every strobe against the expected-event queues.
    initial begin : compare
        logic err_prev;
        bit   now;
        ev_t  e;
        err_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                err_prev = 1'b0;
                continue;
            end
            now = wr_q.size() > 0 && wr_q[0].cyc == cyc;
            chk("reg_wr_en", reg_wr_en, now);
            if (now) begin
                e = wr_q.pop_front();
                chk("wr_addr", reg_addr, e.a);
                chk("wr_data", reg_wr_data, e.d);
            end
            if (reg_wr_en) begin n_wr++; last_wr_addr = reg_addr; last_wr_data = reg_wr_data; end

            now = rd_q.size() > 0 && rd_q[0].cyc == cyc;
            chk("reg_rd_en", reg_rd_en, now);
            chk("tx_load", tx_load, now);
            if (now) begin
                e = rd_q.pop_front();
                chk("rd_addr", reg_addr, e.a);
                chk("tx_data", tx_data, e.d);
            end
            if (reg_rd_en) begin n_rd++; last_rd_addr = reg_addr; last_tx = tx_data; end

            now = bm_q.size() > 0 && bm_q[0].cyc == cyc;
            chk("bram_wr_en", bram_wr_en, now);
            if (now) begin
                e = bm_q.pop_front();
                chk("bram_addr", bram_addr, e.a);
                chk("bram_data", bram_wr_data, e.d);
            end
            if (bram_wr_en) begin n_bm++; last_bm_addr = bram_addr; end

            now = done_q.size() > 0 && done_q[0] == cyc;
            chk("cfg_done", cfg_done, now);
            if (now) void'(done_q.pop_front());
            if (cfg_done) n_done++;

            now = err_q.size() > 0 && err_q[0] == cyc;
            chk("cfg_error_rise", cfg_error && !err_prev, now);
            if (now) void'(err_q.pop_front());
            err_prev = cfg_error;
        end
    end

    task automatic send_word(input logic [15:0] w, input bit fall, output int k);
        @(posedge clk); #1;
        rx_valid = 1'b1;
        rx_data  = w;
        if (fall) frame_active = 1'b0;
        k = cyc;
    endtask

    task automatic idle();
        @(posedge clk); #1;
        rx_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge clk);
    endtask

    // One frame: header, command, n body words from body[]; drop 0 = frame stays up,
    // 1 = frame falls with the last body word, 2 = frame falls after the last word.
    task automatic packet(input logic [15:0] cmd, input int n, input int drop_in);
        int  k, len, a0, need, drop;
        bit  rd, mdl, complete, fall;
        ev_t e;
        drop = (drop_in == 1 && n == 0) ? 2 : drop_in;
        rd   = cmd[15];
        len  = int'(cmd[14:8]) + 1;
        a0   = int'(cmd[7:0]);
        mdl  = !rd && a0 == 255;
        need = mdl ? DEPTH : len;
        complete = (n == need);

        frame_active = 1'b1;
        send_word(16'hA55A, 1'b0, k);
        idle();
        @(negedge clk);
        chk("err_clr_by_hdr", cfg_error, 0);
        send_word(cmd, 1'b0, k);
        if (rd) begin
            e.cyc = k + 1; e.a = a0; e.d = bank[a0];
            rd_q.push_back(e);
        end
        idle();
        for (int i = 0; i < n; i++) begin
            fall = (drop == 1) && (i == n - 1);
            send_word(body[i], fall, k);
            e.cyc = k + 1;
            if (mdl) begin
                e.a = i; e.d = body[i]; bm_q.push_back(e);
            end else if (rd) begin
                if (i + 1 < len) begin
                    e.a = (a0 + i + 1) & 255; e.d = bank[e.a]; rd_q.push_back(e);
                end
            end else begin
                e.a = (a0 + i) & 255; e.d = body[i]; wr_q.push_back(e);
            end
            if (complete && i == n - 1) done_q.push_back(k + 1);
            else if (fall) err_q.push_back(k + 1);
            idle();
        end
        if (drop == 2) begin
            @(posedge clk); #1;
            frame_active = 1'b0;
            if (!complete) err_q.push_back(cyc + 1);
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("wr_q_left", wr_q.size(), 0);
        chk("rd_q_left", rd_q.size(), 0);
        chk("bm_q_left", bm_q.size(), 0);
        chk("done_q_left", done_q.size(), 0);
        chk("err_q_left", err_q.size(), 0);
        chk("busy_after_pkt", busy, 0);
        chk("cfg_error_level", cfg_error, (drop != 0) && !complete);
        wr_q.delete(); rd_q.delete(); bm_q.delete(); done_q.delete(); err_q.delete();
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("busy_after_reset", busy, 0);
        chk("err_after_reset", cfg_error, 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int w0, r0, b0, d0, k, n, need, drop, lf, a;
        bit rd;
        logic [15:0] cmd;
        for (int i = 0; i < 256; i++) bank[i] = 16'($urandom);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_cfg_error", cfg_error, 0);
        chk("rst_cfg_done", cfg_done, 0);
        chk("rst_reg_wr_en", reg_wr_en, 0);
        chk("rst_reg_rd_en", reg_rd_en, 0);
        chk("rst_tx_load", tx_load, 0);
        chk("rst_bram_wr_en", bram_wr_en, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_reg_addr", reg_addr, 0);
        chk("rst_bram_addr", bram_addr, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Write burst of three at 0x10.
        w0 = n_wr; d0 = n_done;
        body[0] = 16'h1111; body[1] = 16'h2222; body[2] = 16'h3333;
        packet(16'h0210, 3, 2);
        chk("wb_count", n_wr - w0, 3);
        chk("wb_last_addr", last_wr_addr, 8'h12);
        chk("wb_last_data", last_wr_data, 16'h3333);
        chk("wb_done", n_done - d0, 1);

        // Read burst of two at 0x05.
        r0 = n_rd; d0 = n_done;
        body[0] = 16'h0000; body[1] = 16'h0000;
        packet(16'h8105, 2, 2);
        chk("rb_count", n_rd - r0, 2);
        chk("rb_last_addr", last_rd_addr, 8'h06);
        chk("rb_last_tx", last_tx, bank[6]);
        chk("rb_done", n_done - d0, 1);

        // Address wrap into register 0xFF, no BRAM traffic.
        w0 = n_wr; b0 = n_bm;
        body[0] = 16'hD000; body[1] = 16'hD001;
        packet(16'h01FE, 2, 2);
        chk("wrap_last_addr", last_wr_addr, 8'hFF);
        chk("wrap_bram", n_bm - b0, 0);

        // Model load of DEPTH words.
        w0 = n_wr; b0 = n_bm; d0 = n_done;
        for (int i = 0; i < DEPTH; i++) body[i] = 16'hB000 + 16'(i);
        packet(16'h00FF, DEPTH, 0);
        chk("model_count", n_bm - b0, 4);
        chk("model_last_addr", last_bm_addr, 3);
        chk("model_no_reg", n_wr - w0, 0);
        chk("model_done", n_done - d0, 1);

        // Header word inside a write burst is plain data.
        body[0] = 16'hA55A; body[1] = 16'h4444;
        packet(16'h0130, 2, 1);
        chk("hdr_data_last", last_wr_data, 16'h4444);

        // Truncated write: one word of four, then frame falls.
        w0 = n_wr; d0 = n_done;
        body[0] = 16'h7777;
        packet(16'h0320, 1, 2);
        chk("trunc_wr", n_wr - w0, 1);
        chk("trunc_addr", last_wr_addr, 8'h20);
        chk("trunc_no_done", n_done - d0, 0);

        // Non-header words in IDLE are ignored and the sticky error survives them.
        w0 = n_wr; r0 = n_rd; b0 = n_bm;
        frame_active = 1'b1;
        send_word(16'h1234, 1'b0, k); idle();
        @(negedge clk);
        chk("nh_busy1", busy, 0);
        send_word(16'h0010, 1'b0, k); idle();
        @(negedge clk);
        chk("nh_busy2", busy, 0);
        chk("nh_strobes", (n_wr - w0) + (n_rd - r0) + (n_bm - b0), 0);
        chk("nh_err_sticky", cfg_error, 1);

        // Reset in the middle of a write burst.
        frame_active = 1'b1;
        send_word(16'hA55A, 1'b0, k); idle();
        send_word(16'h0510, 1'b0, k); idle();
        for (int i = 0; i < 2; i++) begin
            send_word(16'hC000 + 16'(i), 1'b0, k);
            wr_q.push_back('{cyc: k + 1, a: 16 + i, d: 16'hC000 + 16'(i)});
            idle();
        end
        repeat (2) @(posedge clk);
        pulse_reset();
        chk("rst_mid_q", wr_q.size(), 0);
        wr_q.delete();

        // Truncation with the fall on the word itself, then reset clears the error.
        body[0] = 16'h5151;
        packet(16'h0240, 1, 1);
        chk("trunc2_err", cfg_error, 1);
        pulse_reset();

        // Randomised packets.
        for (int p = 0; p < 40; p++) begin
            rd  = 1'($urandom_range(0, 1));
            lf  = $urandom_range(0, 5);
            a   = ($urandom_range(0, 4) == 0) ? 255 : $urandom_range(0, 255);
            cmd = {rd, 7'(lf), 8'(a)};
            need = (!rd && a == 255) ? DEPTH : lf + 1;
            n = $urandom_range(0, need);
            for (int i = 0; i < 16; i++)
                body[i] = ($urandom_range(0, 7) == 0) ? 16'hA55A : 16'($urandom);
            if (n < need) drop = (n > 0 && $urandom_range(0, 1) == 1) ? 1 : 2;
            else          drop = $urandom_range(0, 2);
            packet(cmd, n, drop);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_interface_burst.md
Name: reg_interface_burst

Overview:
- Packet-layer controller between the SPI slave word stream and the configuration register bank / model-data BRAM.
- Adds features for the next NPU generation:
  - command word with read/write select and burst length
  - auto-incrementing register address
  - streaming model-data writes into BRAM with a pointer counter
  - detection of truncated frames, with a sticky error flag.
- Parametrised in word width, address width, header value and BRAM depth.

Parameters:
DATA_W, 16, SPI word / register width
ADDR_W, 8, register address width (must be ≤ 8)
BURST_W, 7, burst-length field width (command bits [14:8])
START_HEADER, 16'hA55A, frame start word
MODEL_DATA_ADDR, 8'hFF, register address that redirects writes to the model BRAM
BRAM_ADDR_W, 10, model BRAM address width
BRAM_DEPTH, 1024, number of model BRAM words per load

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
frame_active  input  1  chip-select active, already synchronised to clk
rx_valid  input  1  one-cycle pulse: a complete word was received
rx_data  input  DATA_W  received word, valid with rx_valid
tx_load  output  1  one-cycle pulse: load tx_data into the SPI shifter
tx_data  output  DATA_W  read-back word
reg_wr_en  output  1  register write strobe
reg_rd_en  output  1  register read strobe
reg_addr  output  ADDR_W  register address
reg_wr_data  output  DATA_W  register write data
reg_rd_data  input  DATA_W  register read data, combinational, same cycle as reg_rd_en
bram_wr_en  output  1  model BRAM write strobe
bram_addr  output  BRAM_ADDR_W  model BRAM address
bram_wr_data  output  DATA_W  model BRAM write data
cfg_done  output  1  one-cycle pulse: packet completed
cfg_error  output  1  sticky error flag
busy  output  1  high when state != IDLE

Behaviour:
- Reset: state IDLE. All strobes, cfg_done, cfg_error, busy = 0. Address, count and pointer registers = 0. tx_data = 0.
- All outputs are registered. Every strobe is asserted exactly one cycle after the rx_valid that caused it.
- States: IDLE, CMD, WRITE, READ, MODEL, DONE, ERROR.
- IDLE:
  - rx_valid with rx_data == START_HEADER → CMD, and cfg_error clears.
  - Any other word is ignored.
- CMD: on rx_valid, latch:
  - rw = rx_data[15] (1 = read)
  - len = rx_data[14:8] + 1, range 1..128; count is BURST_W+1 bits
  - addr = rx_data[ADDR_W-1:0]
  - count = 0
- CMD transitions:
  - Write with addr == MODEL_DATA_ADDR → MODEL, with ptr = 0.
  - Other write → WRITE.
  - Read → READ. In the next cycle, issue reg_rd_en with reg_addr = addr, plus tx_load with tx_data = reg_rd_data.
- WRITE: each rx_valid produces:
  - reg_wr_en, reg_addr = addr, reg_wr_data = rx_data
  - addr increments modulo 2^ADDR_W; count increments
  - When count reaches len → DONE.
  - A word equal to START_HEADER inside WRITE is treated as data.
- READ:
  - Each rx_valid (dummy word while read data shifts out) increments count.
  - If count == len → DONE.
  - Otherwise addr++ and the next cycle issues reg_rd_en + tx_load for the new address.
- MODEL:
  - len is ignored.
  - Each rx_valid produces bram_wr_en, bram_addr = ptr, bram_wr_data = rx_data; ptr++.
  - After the write at ptr == BRAM_DEPTH-1 → DONE. ptr never wraps within a load.
- DONE: cfg_done = 1 for one cycle → IDLE.
- Truncation:
  - A 1→0 edge of frame_active (registered compare) while in CMD, WRITE, READ or MODEL → ERROR.
  - ERROR sets cfg_error and → IDLE after one cycle. No cfg_done.
- Simultaneous rx_valid and frame_active fall: the word is processed first. If it completes the packet → DONE, else → ERROR.
- frame_active falling in IDLE or DONE is not an error.
- reset asserted mid-packet:
  - Returns to IDLE next edge and clears cfg_error.
  - Partial writes already issued are not undone.

Test Plan:
- Write burst: A55A, 0x0210, 0x1111, 0x2222, 0x3333 → reg_wr_en ×3 at addr 0x10/0x11/0x12 with the data in order; one cfg_done; cfg_error = 0.
- Read burst: A55A, 0x8105, dummy, dummy → reg_rd_en + tx_load at addr 0x05, then 0x06; tx_data = bank contents; cfg_done after the 2nd dummy.
- Address wrap: A55A, 0x01FE, d0, d1 → writes at 0xFE then 0xFF. The 0xFF write goes to the BRAM path only if the command addr was 0xFF. This case writes register 0xFF via addr increment with no BRAM strobe.
- Model load with BRAM_DEPTH = 4: A55A, 0x00FF, w0..w3 → bram_wr_en at addr 0..3; cfg_done after w3; reg_wr_en never asserted.
- Truncation: A55A, 0x0320, one word, then frame_active drops → one reg_wr_en at 0x20; cfg_error = 1; no cfg_done. The next A55A clears cfg_error.
- Non-header in IDLE: 0x1234, 0x0010 → no strobes, busy stays 0. Assert reset during WRITE → busy = 0 on the next cycle.
